pc_gen: RTL and testbench



---
 rtl/pc_gen.sv | 151 +++++++++++++++
 tb/tb_pc_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: next-PC generator for the RV32 fetch stage.
//
// Holds the architectural fetch PC and picks the next one from four sources,
// highest priority first: trap vector, branch/jump redirect, hold, and
// sequential increment. It issues a valid/ready request to instruction memory
// and counts the fetches that memory accepts.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   synchronous active-low reset
//   stall          in   pipeline hazard hold; freezes the PC
//   redirect_valid in   branch/jump taken this cycle
//   redirect_addr  in   branch/jump target (XLEN)
//   trap_valid     in   exception/interrupt entry
//   trap_addr      in   trap vector target (XLEN)
//   fetch_ready    in   instruction memory accepts the request
//   fetch_valid    out  fetch request valid
//   fetch_addr     out  instruction-memory address, pc[ADDR_WIDTH-1:0]
//   pc_out         out  current PC to IF/ID
//   flush_out      out  registered pulse; IF/ID discards its entry
//   fetch_count    out  number of accepted fetches (wraps)
//   misalign_err   out  only with PC_GEN_MISALIGN_CHECK_EN defined: registered
//                       pulse when a trap/redirect target is not word aligned
//
// Build option PC_GEN_MISALIGN_CHECK_EN: when this macro is defined, a
// misaligned trap/redirect target is not loaded (the PC holds) and
// misalign_err pulses. When it is undefined, targets are loaded as given and
// the misalign_err port does not exist.

module pc_gen #(
  parameter int unsigned     XLEN             = 32,
  parameter int unsigned     INST_MEMORY_SIZE = 16384,
  parameter int unsigned     ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
  parameter logic [XLEN-1:0] RESET_VECTOR     = '0,
  parameter int unsigned     INC_BYTES        = 4,
  parameter int unsigned     CNT_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_addr,
  input  logic                  trap_valid,
  input  logic [XLEN-1:0]       trap_addr,
  input  logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [XLEN-1:0]       pc_out,
  output logic                  flush_out,
`ifdef PC_GEN_MISALIGN_CHECK_EN
  output logic                  misalign_err,
`endif
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StWait
  } state_e;

  state_e               state_q;
  logic [XLEN-1:0]      pc_q;
  logic                 flush_q;
  logic [CNT_WIDTH-1:0] fetch_count_q;
`ifdef PC_GEN_MISALIGN_CHECK_EN
  logic                 misalign_q;
`endif

  logic            redirect_any;
  logic [XLEN-1:0] target;
  logic            accept;

  // Trap takes priority over a same-cycle redirect.
  assign redirect_any = trap_valid | redirect_valid;
  assign target       = trap_valid ? trap_addr : redirect_addr;

  // Only RUN looks at stall; once a request is outstanding (WAIT) it is held
  // until memory takes it or a trap/redirect abandons it.
  always_comb begin
    fetch_valid = 1'b0;
    case (state_q)
      StBoot:  fetch_valid = 1'b0;
      StRun:   fetch_valid = ~stall;
      StWait:  fetch_valid = 1'b1;
      default: fetch_valid = 1'b0;
    endcase
  end

  assign accept = fetch_valid & fetch_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      flush_q       <= 1'b0;
      fetch_count_q <= '0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      flush_q    <= 1'b0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      if (redirect_any) begin
        // A redirect squashes whatever was in flight, including a WAIT
        // request, and the fetch counter does not advance this cycle.
        state_q <= StRun;
        flush_q <= 1'b1;
`ifdef PC_GEN_MISALIGN_CHECK_EN
        if (target[1:0] != 2'b00) begin
          misalign_q <= 1'b1;
        end else begin
          pc_q <= target;
        end
`else
        pc_q <= target;
`endif
      end else begin
        case (state_q)
          StBoot: state_q <= StRun;
          StRun: begin
            if (fetch_valid && !fetch_ready) begin
              state_q <= StWait;
            end
          end
          StWait: begin
            if (fetch_ready) begin
              state_q <= StRun;
            end
          end
          default: state_q <= StBoot;
        endcase
        if (accept) begin
          pc_q          <= pc_q + XLEN'(INC_BYTES);
          fetch_count_q <= fetch_count_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign pc_out      = pc_q;
  assign fetch_addr  = pc_q[ADDR_WIDTH-1:0];
  assign flush_out   = flush_q;
  assign fetch_count = fetch_count_q;
`ifdef PC_GEN_MISALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen. Each test drives one cycle per table row,
// pushes that cycle's expected outputs into a scoreboard queue, and pops and
// compares them on the falling edge while the DUT holds the cycle's outputs.
// The counter is built narrow (8 bits) so that its wrap can be reached quickly.

module tb_pc_gen;

  localparam int unsigned CW = 8;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        rdy;
    logic        rv;
    logic [31:0] ra;
    logic        tv;
    logic [31:0] ta;
  } stim_t;

  typedef struct packed {
    logic [31:0]   pc;
    logic [13:0]   fa;
    logic          fv;
    logic          fl;
    logic [CW-1:0] cnt;
    logic          me;
  } obs_t;

`ifdef PC_GEN_MISALIGN_CHECK_EN
  localparam logic [31:0] MisPc = 32'h0000_03D8;  // misaligned target is rejected
  localparam logic        MisMe = 1'b1;
`else
  localparam logic [31:0] MisPc = 32'h0000_0102;  // loaded unmodified
  localparam logic        MisMe = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_addr;
  logic          trap_valid;
  logic [31:0]   trap_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [13:0]   fetch_addr;
  logic [31:0]   pc_out;
  logic          flush_out;
  logic [CW-1:0] fetch_count;
  logic          me_obs;

  int   n_pass  = 0;
  int   n_total = 0;
  obs_t exp_q[$];

  pc_gen #(
    .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .trap_valid    (trap_valid),
    .trap_addr     (trap_addr),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .fetch_addr    (fetch_addr),
    .pc_out        (pc_out),
    .flush_out     (flush_out),
`ifdef PC_GEN_MISALIGN_CHECK_EN
    .misalign_err  (me_obs),
`endif
    .fetch_count   (fetch_count)
  );

`ifndef PC_GEN_MISALIGN_CHECK_EN
  assign me_obs = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t s_in(logic rst_n, logic st, logic rdy, logic rv,
                                 logic [31:0] ra, logic tv, logic [31:0] ta);
    s_in = '{rst_n: rst_n, stall: st, rdy: rdy, rv: rv, ra: ra, tv: tv, ta: ta};
  endfunction

  function automatic obs_t e_out(logic [31:0] pc, logic fv, logic fl, logic [CW-1:0] cnt,
                                 logic me);
    e_out = '{pc: pc, fa: pc[13:0], fv: fv, fl: fl, cnt: cnt, me: me};
  endfunction

  function automatic obs_t sample();
    sample = '{pc: pc_out, fa: fetch_addr, fv: fetch_valid, fl: flush_out, cnt: fetch_count,
               me: me_obs};
  endfunction

  function automatic string fmt(obs_t o);
    fmt = $sformatf("pc=%h fa=%h fv=%b fl=%b cnt=%0d me=%b", o.pc, o.fa, o.fv, o.fl, o.cnt, o.me);
  endfunction

  task automatic apply(stim_t s);
    reset_n        = s.rst_n;
    stall          = s.stall;
    fetch_ready    = s.rdy;
    redirect_valid = s.rv;
    redirect_addr  = s.ra;
    trap_valid     = s.tv;
    trap_addr      = s.ta;
  endtask

  task automatic test_reset();
    obs_t got, e;
    apply(s_in(0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(e_out(32'h0, 0, 0, 0, 0));
    @(negedge clk);
    got = sample(); e = exp_q.pop_front(); n_total++;
    if (got !== e) $display("FAIL reset: got %s, expected %s", fmt(got), fmt(e));
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_boot_seq();
    stim_t st[5];
    obs_t  ex[5];
    obs_t  got, e;
    st = '{default: s_in(1, 0, 1, 0, 0, 0, 0)};
    ex = '{e_out(32'h0, 0, 0, 0, 0), e_out(32'h0, 1, 0, 0, 0), e_out(32'h4, 1, 0, 1, 0),
           e_out(32'h8, 1, 0, 2, 0), e_out(32'hC, 1, 0, 3, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL boot_seq[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait();
    stim_t st[5];
    obs_t  ex[5];
    obs_t  got, e;
    st = '{s_in(1, 0, 0, 0, 0, 0, 0), s_in(1, 0, 0, 0, 0, 0, 0), s_in(1, 1, 0, 0, 0, 0, 0),
           s_in(1, 0, 1, 0, 0, 0, 0), s_in(1, 0, 1, 0, 0, 0, 0)};
    ex = '{e_out(32'h10, 1, 0, 4, 0), e_out(32'h10, 1, 0, 4, 0), e_out(32'h10, 1, 0, 4, 0),
           e_out(32'h10, 1, 0, 4, 0), e_out(32'h14, 1, 0, 5, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL wait[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    stim_t st[5];
    obs_t  ex[5];
    obs_t  got, e;
    st = '{s_in(1, 0, 1, 0, 0, 0, 0), s_in(1, 0, 1, 0, 0, 0, 0), s_in(1, 1, 1, 0, 0, 0, 0),
           s_in(1, 1, 1, 0, 0, 0, 0), s_in(1, 0, 1, 0, 0, 0, 0)};
    ex = '{e_out(32'h18, 1, 0, 6, 0), e_out(32'h1C, 1, 0, 7, 0), e_out(32'h20, 0, 0, 8, 0),
           e_out(32'h20, 0, 0, 8, 0), e_out(32'h20, 1, 0, 8, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL stall[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // Trap and redirect together while a request is waiting: trap wins, the
  // request is abandoned and the counter does not advance despite ready.
  task automatic test_trap_redirect();
    stim_t st[4];
    obs_t  ex[4];
    obs_t  got, e;
    st = '{s_in(1, 0, 0, 0, 0, 0, 0), s_in(1, 0, 1, 1, 32'h100, 1, 32'h80),
           s_in(1, 0, 1, 0, 0, 0, 0), s_in(1, 0, 1, 1, 32'h200, 0, 0)};
    ex = '{e_out(32'h24, 1, 0, 9, 0), e_out(32'h24, 1, 0, 9, 0), e_out(32'h80, 1, 1, 9, 0),
           e_out(32'h84, 1, 0, 10, 0)};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL trap_redirect[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // Back-to-back redirects, a target above the memory range, and a redirect
  // taken under stall.
  task automatic test_back_to_back();
    stim_t st[4];
    obs_t  ex[4];
    obs_t  got, e;
    st = '{s_in(1, 0, 1, 1, 32'h1234_5678, 0, 0), s_in(1, 0, 1, 0, 0, 0, 0),
           s_in(1, 1, 1, 1, 32'h300, 0, 0), s_in(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0)};
    ex = '{e_out(32'h200, 1, 1, 10, 0), e_out(32'h1234_5678, 1, 1, 10, 0),
           e_out(32'h1234_567C, 0, 0, 11, 0), e_out(32'h300, 1, 1, 11, 0)};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // PC wraps from the top of the address space, then the counter wraps.
  task automatic test_wrap();
    obs_t got, e;
    logic [CW-1:0] cnt;
    for (int k = -1; k < 246; k++) begin
      apply(s_in(1, 0, 1, 0, 0, 0, 0));
      cnt = CW'(12 + k);
      if (k < 0) exp_q.push_back(e_out(32'hFFFF_FFFC, 1, 1, 11, 0));
      else exp_q.push_back(e_out(32'(4 * k), 1, 0, cnt, 0));
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL wrap[%0d]: got %s, expected %s", k, fmt(got), fmt(e));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // Misaligned redirect, then reset asserted alongside a redirect.
  task automatic test_misalign_reset();
    stim_t st[4];
    obs_t  ex[4];
    obs_t  got, e;
    st = '{s_in(1, 0, 1, 1, 32'h102, 0, 0), s_in(1, 0, 1, 0, 0, 0, 0),
           s_in(0, 0, 1, 1, 32'h500, 0, 0), s_in(0, 0, 1, 0, 0, 0, 0)};
    ex = '{e_out(32'h3D8, 1, 0, 2, 0), e_out(MisPc, 1, 1, 2, MisMe),
           e_out(MisPc + 32'h4, 1, 0, 3, 0), e_out(32'h0, 0, 0, 0, 0)};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL misalign_reset[%0d]: got %s, expected %s", i, fmt(got),
                              fmt(e));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // A trap during the BOOT cycle is taken immediately.
  task automatic test_boot_trap();
    stim_t st[3];
    obs_t  ex[3];
    obs_t  got, e;
    st = '{s_in(1, 0, 1, 0, 0, 1, 32'h40), s_in(1, 0, 1, 0, 0, 0, 0),
           s_in(1, 0, 1, 0, 0, 0, 0)};
    ex = '{e_out(32'h0, 0, 0, 0, 0), e_out(32'h40, 1, 1, 0, 0), e_out(32'h44, 1, 0, 1, 0)};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); n_total++;
      if (got !== e) $display("FAIL boot_trap[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(s_in(0, 0, 1, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_boot_seq();
    test_wait();
    test_stall();
    test_trap_redirect();
    test_back_to_back();
    test_wrap();
    test_misalign_reset();
    test_boot_trap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
